hex_wb_ctrl: RTL and testbench
==============================

# hex_wb_ctrl

Wishbone master that drives the four-digit seven-segment display peripheral from a 16-bit value. Accepts a value over a valid/ready handshake, decodes each nibble to a segment pattern, and issues one classic single write per changed digit to peripheral addresses 0..3. Handles ack/err/rty and a response timeout. Sits between a status/debug source and the display slave on the shared 8-bit Wishbone bus.

## Interface
- TIMEOUT, 255: cycles stb may stay high without ack/err/rty before abort; 0 disables timeout
- RETRY_MAX, 3: rty responses tolerated per digit before it is declared failed
- SKIP_UNCHANGED, 1: 1 = skip digits whose pattern equals the last successfully written one
- SEG_INVERT, 0: 1 = invert bits 6:0 of every written pattern (common-anode panels)

- wb_clk  in  1  clock, all logic on rising edge
- wb_rst_n  in  1  synchronous, active-low reset
- val_i  in  16  value; digit n = val_i[4n+3:4n]
- blank_i  in  4  per-digit blank; segments 6:0 forced 0 (before inversion)
- dp_i  in  4  per-digit decimal point, driven on data bit 7
- val_valid_i  in  1  value offered
- val_ready_o  out  1  controller idle; transfer on valid & ready
- wbm_adr_o  out  2  digit address
- wbm_dat_o  out  8  {dp, pattern[6:0]}
- wbm_we_o, wbm_cyc_o, wbm_stb_o  out  1  each; we=cyc=stb
- wbm_cti_o  out  3  constant 3'b000
- wbm_bte_o  out  2  constant 2'b00
- wbm_dat_i  in  8  unused
- wbm_ack_i, wbm_err_i, wbm_rty_i  in  1  each  slave response
- busy_o  out  1  not idle
- done_o  out  1  one-cycle pulse, update sequence finished
- err_o  out  1  sticky: a digit failed in the current/last sequence

## Operation
- Decode (bit0=a..bit6=g, 1=lit): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- States: IDLE, SEL, WR, GAP.
- IDLE: val_ready_o=1. On valid&ready capture val_i, blank_i, dp_i; digit index=0; clear err_o; -> SEL.
- SEL: compute byte for current digit. If SKIP_UNCHANGED and shadow valid and byte==shadow -> advance (next digit -> SEL; after digit 3 -> IDLE with done). Else -> WR, reset timeout counter.
- WR: cyc=stb=we=1, adr=digit, dat=byte. Response priority err > ack > rty.
  - ack: shadow[digit]=byte, valid=1; retry count=0; -> GAP, advance.
  - err, timeout, or rty with retry count==RETRY_MAX: err_o=1, shadow[digit] invalid, retry count=0; -> GAP, advance.
  - rty otherwise: retry count+1; -> GAP, same digit (re-enters SEL, re-issues).
  - no response: timeout counter +1; when it reaches TIMEOUT (nonzero) it is a timeout.
- GAP: cyc=stb=0 one cycle (required so the slave's registered ack drops); -> SEL or, after digit 3 advanced, IDLE.
- Returning to IDLE: done_o=1 that cycle, val_ready_o=1 same cycle.
- Shadow: 4×8-bit + valid bits; only written on ack.
- Reset (any state): next cycle all outputs 0 except val_ready_o=1; state IDLE, shadow invalid, counters 0. An in-flight bus cycle is dropped.

## Timing
- Reset values: cyc/stb/we/adr/dat/done/err/busy=0, val_ready_o=1.
- Handshake edge E0; cycle k = k-th cycle after E0.
- Written digit against the display slave (ack one cycle after stb): SEL, WR, WR(ack seen), GAP = 4 cycles. Skipped digit: SEL only = 1 cycle.
- All four written: stb high cycles 2-3, 6-7, 10-11, 14-15; done_o and val_ready_o in cycle 17.
- All skipped: done_o in cycle 5.
- Timeout: stb high exactly TIMEOUT cycles, then GAP.
- busy_o = !val_ready_o.

## Test plan
- Reset, val=0x1234, blank=0, dp=0 -> writes adr0 0x66, adr1 0x4F, adr2 0x5B, adr3 0x06 at stb cycles above; done_o cycle 17; slave hex0..3 = 66/4F/5B/06; err_o=0.
- Same value again -> no cyc, done_o cycle 5; then 0x1235 -> single write adr0 0x6D, done_o cycle 8.
- val=0xABCD, blank=4'b1000, dp=4'b0001 -> adr0 0xDE, adr1 0x39, adr2 0x7C, adr3 0x00.
- TIMEOUT=8, slave never acks adr1 -> stb high 8 cycles then dropped, err_o=1, adr2/adr3 still written; next identical value rewrites adr1 (shadow invalid).
- rty once on adr0 -> GAP, SEL, re-issue adr0, ack, no error; rty 4 times on adr0 -> 4 attempts, err_o=1, sequence continues.
- Reset low during WR of digit 2 -> next cycle cyc/stb=0, val_ready_o=1; same value resubmitted -> all 4 digits written.

Source files
------------

// File: rtl/hex_wb_ctrl.sv
// Drives a 4-digit 7-segment display over Wishbone: one single write per changed digit.
// Latency: 4 cycles per written digit (SEL, WR, ack, GAP), 1 per skipped digit.
// Backpressure: val_ready_o is low for the whole update sequence; values are accepted only in IDLE.
module hex_wb_ctrl #(
  parameter int TIMEOUT        = 255,
  parameter int RETRY_MAX      = 3,
  parameter bit SKIP_UNCHANGED = 1'b1,
  parameter bit SEG_INVERT     = 1'b0
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [15:0] val_i,
  input  logic [3:0]  blank_i,
  input  logic [3:0]  dp_i,
  input  logic        val_valid_i,
  output logic        val_ready_o,
  output logic [1:0]  wbm_adr_o,
  output logic [7:0]  wbm_dat_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [7:0]  wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEL  = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]  state_q;
  logic [15:0] val_q;
  logic [3:0]  blank_q;
  logic [3:0]  dp_q;
  // dig_q[2] set means digit 3 has been advanced past: sequence is over
  logic [2:0]  dig_q;
  logic [15:0] tmo_cnt_q;
  logic [7:0]  rty_cnt_q;
  logic [7:0]  shadow_q [4];
  logic [3:0]  shadow_vld_q;
  logic        done_q;
  logic        err_q;

  logic [1:0]  cur_dig;
  logic [3:0]  cur_nib;
  logic [6:0]  seg_raw;
  logic [6:0]  seg;
  logic [7:0]  cur_byte;
  logic        tmo_hit;
  logic        is_wr;
  logic        unused_dat;

  assign cur_dig    = dig_q[1:0];
  assign is_wr      = (state_q == S_WR);
  assign tmo_hit    = (TIMEOUT != 0) && (tmo_cnt_q == 16'(TIMEOUT - 1));
  assign unused_dat = ^wbm_dat_i;

  // Select the current nibble and decode it to the byte placed on the bus
  always_comb begin
    cur_nib = val_q[{cur_dig, 2'b00} +: 4];
    case (cur_nib)
      4'h0:    seg_raw = 7'h3F;
      4'h1:    seg_raw = 7'h06;
      4'h2:    seg_raw = 7'h5B;
      4'h3:    seg_raw = 7'h4F;
      4'h4:    seg_raw = 7'h66;
      4'h5:    seg_raw = 7'h6D;
      4'h6:    seg_raw = 7'h7D;
      4'h7:    seg_raw = 7'h07;
      4'h8:    seg_raw = 7'h7F;
      4'h9:    seg_raw = 7'h6F;
      4'hA:    seg_raw = 7'h77;
      4'hB:    seg_raw = 7'h7C;
      4'hC:    seg_raw = 7'h39;
      4'hD:    seg_raw = 7'h5E;
      4'hE:    seg_raw = 7'h79;
      default: seg_raw = 7'h71;
    endcase
    // Blanking applies to the logical pattern; inversion is a panel property applied last
    seg = blank_q[cur_dig] ? 7'h00 : seg_raw;
    if (SEG_INVERT) begin
      seg = ~seg;
    end
    cur_byte = {dp_q[cur_dig], seg};
  end

  // Sequencer: capture, per-digit skip/write decision, response handling, shadow update
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q      <= S_IDLE;
      val_q        <= '0;
      blank_q      <= '0;
      dp_q         <= '0;
      dig_q        <= '0;
      tmo_cnt_q    <= '0;
      rty_cnt_q    <= '0;
      shadow_vld_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (val_valid_i) begin
            val_q     <= val_i;
            blank_q   <= blank_i;
            dp_q      <= dp_i;
            dig_q     <= '0;
            rty_cnt_q <= '0;
            err_q     <= 1'b0;
            state_q   <= S_SEL;
          end
        end
        S_SEL: begin
          if (SKIP_UNCHANGED && shadow_vld_q[cur_dig] && (shadow_q[cur_dig] == cur_byte)) begin
            if (cur_dig == 2'd3) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end else begin
              dig_q <= dig_q + 3'd1;
            end
          end else begin
            tmo_cnt_q <= '0;
            state_q   <= S_WR;
          end
        end
        S_WR: begin
          if (wbm_err_i || (!wbm_ack_i && wbm_rty_i && (rty_cnt_q == 8'(RETRY_MAX)))
              || (!wbm_ack_i && !wbm_rty_i && tmo_hit)) begin
            // Digit failed: forget what the slave holds so the next request rewrites it
            err_q                 <= 1'b1;
            shadow_vld_q[cur_dig] <= 1'b0;
            rty_cnt_q             <= '0;
            dig_q                 <= dig_q + 3'd1;
            state_q               <= S_GAP;
          end else if (wbm_ack_i) begin
            shadow_q[cur_dig]     <= cur_byte;
            shadow_vld_q[cur_dig] <= 1'b1;
            rty_cnt_q             <= '0;
            dig_q                 <= dig_q + 3'd1;
            state_q               <= S_GAP;
          end else if (wbm_rty_i) begin
            // Same digit is reissued after the gap
            rty_cnt_q <= rty_cnt_q + 8'd1;
            state_q   <= S_GAP;
          end else if (TIMEOUT != 0) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        default: begin
          // One idle bus cycle lets the slave's registered response drop
          if (dig_q[2]) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_SEL;
          end
        end
      endcase
    end
  end

  assign val_ready_o = (state_q == S_IDLE);
  assign busy_o      = ~val_ready_o;
  assign wbm_cyc_o   = is_wr;
  assign wbm_stb_o   = is_wr;
  assign wbm_we_o    = is_wr;
  assign wbm_adr_o   = is_wr ? cur_dig : 2'd0;
  assign wbm_dat_o   = is_wr ? cur_byte : 8'h00;
  assign wbm_cti_o   = 3'b000;
  assign wbm_bte_o   = 2'b00;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_hex_wb_ctrl.sv
// Bench for hex_wb_ctrl: behavioural display slave, transaction-level reference model, scoreboard monitor.
// Latency: expected bus start cycles and done cycle are derived per request from the model.
// Backpressure: requests are offered only after the previous sequence's done pulse.
module tb_hex_wb_ctrl;

  localparam int TMO    = 8;
  localparam int RMAX   = 3;
  localparam bit SINV   = 1'b0;
  localparam int R_ACK  = 0;
  localparam int R_ERR  = 1;
  localparam int R_RTY  = 2;
  localparam int R_NONE = 3;

  logic        wb_clk;
  logic        wb_rst_n;
  logic [15:0] val_i;
  logic [3:0]  blank_i;
  logic [3:0]  dp_i;
  logic        val_valid_i;
  logic        val_ready_o;
  logic [1:0]  wbm_adr_o;
  logic [7:0]  wbm_dat_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [7:0]  wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_rty_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  hex_wb_ctrl #(
    .TIMEOUT(TMO), .RETRY_MAX(RMAX), .SKIP_UNCHANGED(1'b1), .SEG_INVERT(SINV)
  ) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .val_i(val_i), .blank_i(blank_i), .dp_i(dp_i),
    .val_valid_i(val_valid_i), .val_ready_o(val_ready_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         start;
    int         len;
    logic [1:0] adr;
    logic [7:0] dat;
  } acc_t;
  typedef struct {
    int   cyc;
    logic err;
  } done_t;

  acc_t  exp_acc[$];
  done_t exp_done[$];
  int    plan_q[$];
  int    slave_q[$];

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [7:0] m_shadow [4];
  bit         m_sv [4];
  logic [7:0] m_disp [4];

  // Reference: walk the digits, consume the planned slave responses, accumulate cycle time
  task automatic model_run(input logic [15:0] v, input logic [3:0] b, input logic [3:0] dp);
    int t;
    int p;
    int tries;
    int code;
    int len;
    bit e;
    bit fin;
    logic [3:0] n;
    logic [6:0] s;
    logic [7:0] bt;
    t = 1;
    p = 0;
    e = 1'b0;
    for (int d = 0; d < 4; d++) begin
      n  = v[4*d +: 4];
      bt = seg_tab[n];
      s  = b[d] ? 7'h00 : bt[6:0];
      if (SINV) s = ~s;
      bt = {dp[d], s};
      if (m_sv[d] && m_shadow[d] == bt) begin
        t++;
      end else begin
        tries = 0;
        fin = 1'b0;
        while (!fin) begin
          code = (p < plan_q.size()) ? plan_q[p] : R_ACK;
          p++;
          len = (code == R_NONE) ? TMO : 2;
          exp_acc.push_back('{t + 1, len, 2'(d), bt});
          t = t + len + 2;
          if (code == R_ACK) begin
            m_shadow[d] = bt;
            m_sv[d] = 1'b1;
            m_disp[d] = bt;
            fin = 1'b1;
          end else if (code == R_RTY && tries < RMAX) begin
            tries++;
          end else begin
            e = 1'b1;
            m_sv[d] = 1'b0;
            fin = 1'b1;
          end
        end
      end
    end
    exp_done.push_back('{t, e});
  endtask

  // Display slave: registered single response per strobe, as dictated by the plan
  logic [7:0] hex [4];
  bit s_started;
  bit s_resp;
  int s_code;
  always @(posedge wb_clk) begin
    wbm_ack_i <= 1'b0;
    wbm_err_i <= 1'b0;
    wbm_rty_i <= 1'b0;
    if (wbm_cyc_o && wbm_stb_o) begin
      if (!s_started) begin
        s_started = 1'b1;
        s_resp = 1'b0;
        s_code = (slave_q.size() > 0) ? slave_q.pop_front() : R_ACK;
      end
      if (!s_resp && s_code != R_NONE) begin
        s_resp = 1'b1;
        if (s_code == R_ACK) begin
          wbm_ack_i <= 1'b1;
          hex[wbm_adr_o] <= wbm_dat_o;
        end else if (s_code == R_ERR) begin
          wbm_err_i <= 1'b1;
        end else begin
          wbm_rty_i <= 1'b1;
        end
      end
    end else begin
      s_started = 1'b0;
    end
  end

  // Monitor: cycle count from the handshake edge, compare each bus access and done pulse
  int   k = 0;
  bit   hs = 1'b0;
  bit   pstb = 1'b0;
  bit   mon_en = 1'b1;
  int   st_k = 0;
  int   st_len = -1;
  acc_t ma;
  done_t md;
  always @(negedge wb_clk) begin
    if (hs) k = 1; else k++;
    if (mon_en) begin
      if (wbm_stb_o && !pstb) begin
        st_k = k;
        if (exp_acc.size() == 0) begin
          checks++;
          failures++;
          st_len = -1;
          $display("FAIL unexpected_access: adr=%0d dat=%02h cycle=%0d", wbm_adr_o, wbm_dat_o, k);
        end else begin
          ma = exp_acc.pop_front();
          st_len = ma.len;
          chk("acc_start_cycle", k, ma.start);
          chk("acc_adr", wbm_adr_o, ma.adr);
          chk("acc_dat", wbm_dat_o, ma.dat);
          chk("acc_cyc_we", {wbm_cyc_o, wbm_we_o, wbm_cti_o, wbm_bte_o}, 7'b1100000);
        end
      end
      if (!wbm_stb_o && pstb && st_len >= 0) begin
        chk("stb_len", k - st_k, st_len);
      end
      if (done_o) begin
        if (exp_done.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: cycle=%0d", k);
        end else begin
          md = exp_done.pop_front();
          chk("done_cycle", k, md.cyc);
          chk("done_err", err_o, md.err);
          chk("done_ready", {val_ready_o, busy_o}, 2'b10);
          chk("acc_left", exp_acc.size(), 0);
        end
      end
    end
    pstb = wbm_stb_o;
    hs = val_valid_i && val_ready_o && wb_rst_n;
  end

  task automatic submit(input logic [15:0] v, input logic [3:0] b, input logic [3:0] dp);
    int n;
    slave_q = plan_q;
    model_run(v, b, dp);
    plan_q.delete();
    @(posedge wb_clk);
    #1;
    val_i = v;
    blank_i = b;
    dp_i = dp;
    val_valid_i = 1'b1;
    n = 0;
    while (!val_ready_o && n < 100) begin
      @(posedge wb_clk);
      #1;
      n++;
    end
    chk("ready_seen", val_ready_o, 1'b1);
    @(posedge wb_clk);
    #1;
    val_valid_i = 1'b0;
    n = 0;
    while (!done_o && n < 500) begin
      @(negedge wb_clk);
      n++;
    end
    chk("done_seen", done_o, 1'b1);
    for (int d = 0; d < 4; d++) chk("slave_hex", hex[d], m_disp[d]);
    repeat (2) @(posedge wb_clk);
    slave_q.delete();
  endtask

  logic [15:0] rv;
  logic [15:0] prev_v;
  int n_w;

  initial begin
    wb_rst_n = 1'b0;
    val_i = '0;
    blank_i = '0;
    dp_i = '0;
    val_valid_i = 1'b0;
    wbm_dat_i = '0;
    for (int d = 0; d < 4; d++) begin
      hex[d] = '0;
      m_disp[d] = '0;
      m_shadow[d] = '0;
      m_sv[d] = 1'b0;
    end
    repeat (3) @(posedge wb_clk);
    #1;
    chk("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o}, 13'h0);
    chk("rst_status", {val_ready_o, busy_o, done_o, err_o}, 4'b1000);
    chk("rst_cti_bte", {wbm_cti_o, wbm_bte_o}, 5'b0);
    wb_rst_n = 1'b1;

    submit(16'h1234, 4'b0000, 4'b0000);
    submit(16'h1234, 4'b0000, 4'b0000);
    submit(16'h1235, 4'b0000, 4'b0000);
    submit(16'hABCD, 4'b1000, 4'b0001);
    plan_q = '{R_ACK, R_NONE, R_ACK, R_ACK};
    submit(16'h5678, 4'b0000, 4'b0000);
    submit(16'h5678, 4'b0000, 4'b0000);
    plan_q = '{R_RTY, R_ACK};
    submit(16'h5679, 4'b0000, 4'b0000);
    plan_q = '{R_RTY, R_RTY, R_RTY, R_RTY};
    submit(16'h567A, 4'b0000, 4'b0000);
    plan_q = '{R_ACK, R_ERR};
    submit(16'h1111, 4'b0000, 4'b0000);

    // Abort a sequence with reset while digit 2 is on the bus
    mon_en = 1'b0;
    @(posedge wb_clk);
    #1;
    val_i = 16'h2468;
    blank_i = '0;
    dp_i = '0;
    val_valid_i = 1'b1;
    @(posedge wb_clk);
    #1;
    val_valid_i = 1'b0;
    n_w = 0;
    while (!(wbm_stb_o && wbm_adr_o == 2'd2) && n_w < 100) begin
      @(posedge wb_clk);
      #1;
      n_w++;
    end
    chk("reach_wr_dig2", {wbm_stb_o, wbm_adr_o}, 3'b110);
    wb_rst_n = 1'b0;
    @(posedge wb_clk);
    #1;
    chk("abort_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 3'b000);
    chk("abort_status", {val_ready_o, busy_o, done_o, err_o}, 4'b1000);
    wb_rst_n = 1'b1;
    for (int d = 0; d < 4; d++) m_sv[d] = 1'b0;
    slave_q.delete();
    repeat (2) @(posedge wb_clk);
    #1;
    mon_en = 1'b1;
    submit(16'h2468, 4'b0000, 4'b0000);

    prev_v = 16'h2468;
    for (int it = 0; it < 40; it++) begin
      rv = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        rv = prev_v;
        if ($urandom_range(0, 1) == 1) rv[4*$urandom_range(0, 3) +: 4] = 4'($urandom);
      end
      for (int j = 0; j < 12; j++) begin
        case ($urandom_range(0, 19))
          0, 1:    plan_q.push_back(R_ERR);
          2, 3, 4: plan_q.push_back(R_RTY);
          5:       plan_q.push_back(R_NONE);
          default: plan_q.push_back(R_ACK);
        endcase
      end
      submit(rv, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000, 4'($urandom));
      prev_v = rv;
    end

    chk("done_queue_empty", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
